// File: rtl/fir_pkg.sv
// Shared definitions for the polyphase interpolating FIR (fir_interp).
// This file holds three things:
//   - the FSM state type,
//   - the fixed prototype coefficient table,
//   - the accumulator sizing function.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Symmetric prototype low-pass filter, stored as h[0] .. h[10].
  localparam int H_TAPS = 11;
  localparam int H_COEF [H_TAPS] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};

  // Full-precision accumulator width.
  // One full product is 2*width bits.
  // The clog2(n) guard bits cover the sum of n products.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// Single time-multiplexed multiply-accumulate unit for fir_interp.
// Each enabled cycle adds one full-precision product a_i*b_i.
// clr_i zeroes the accumulator and takes priority over en_i.
module fir_mac #(
  parameter int WIDTH = 32,
  parameter int ACC_W = 69
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [ACC_W-1:0]   acc_q;

  // Next accumulator value: clear, add one product, or hold.
  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  // Accumulator register (p0 stage).
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/fir_interp.sv
// Polyphase interpolating FIR.
// Each accepted input sample produces L output samples, one per phase.
// A single shared multiplier (fir_mac) evaluates one tap per cycle.
// Output formatting is selected by the FIR_INTERP_SAT_EN macro:
//   - defined:   the accumulator is saturated to the WIDTH-bit signed range,
//   - undefined: the low WIDTH bits are kept (two's complement wrap).
module fir_interp
  import fir_pkg::*;
#(
  parameter int N     = 11,
  parameter int WIDTH = 32,
  parameter int L     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [WIDTH-1:0] y_out,
  output logic                    y_valid,
  input  logic                    y_ready
);

  localparam int HLEN  = (N + L - 1) / L;
  localparam int ACC_W = acc_width(WIDTH, N);

  state_e                  state_q;
  logic [3:0]              phase_q;
  logic [7:0]              k_q;
  logic                    x_ready_q;
  logic                    y_valid_q;
  logic signed [WIDTH-1:0] hist_q [HLEN];

  logic                    accept;
  logic                    last_term;
  logic                    next_phase;
  logic                    mac_clr;
  logic                    mac_en;
  logic signed [WIDTH-1:0] coef;
  logic signed [WIDTH-1:0] samp;
  logic signed [ACC_W-1:0] acc;

  // Number of taps belonging to phase p: ceil((N-p)/L).
  function automatic int n_terms(input int p);
    return (N - p + L - 1) / L;
  endfunction

`ifdef FIR_INTERP_SAT_EN
  // Clamp the full-precision sum into the signed WIDTH-bit range.
  function automatic logic signed [WIDTH-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] maxv;
    logic signed [ACC_W-1:0] minv;
    maxv             = '0;
    maxv[WIDTH-2:0]  = '1;
    minv             = '1;
    minv[WIDTH-2:0]  = '0;
    if (a > maxv) begin
      return {1'b0, {(WIDTH-1){1'b1}}};
    end else if (a < minv) begin
      return {1'b1, {(WIDTH-1){1'b0}}};
    end
    return a[WIDTH-1:0];
  endfunction
`else
  // Keep the low WIDTH bits of the sum (two's complement wrap).
  function automatic logic signed [WIDTH-1:0] fmt_out(input logic signed [ACC_W-1:0] a);
    return a[WIDTH-1:0];
  endfunction
`endif

  assign x_ready    = x_ready_q & ~rst;
  assign y_valid    = y_valid_q & ~rst;
  assign accept     = x_valid & x_ready;
  assign last_term  = (int'(k_q) == n_terms(int'(phase_q)) - 1);
  assign next_phase = (state_q == OUT) && y_ready && (int'(phase_q) < L - 1);
  assign mac_clr    = accept | next_phase;
  assign mac_en     = (state_q == MAC);
  assign y_out      = fmt_out(acc);

  // Operand select.
  // For term k of phase p, the coefficient is h[k*L+p] and the sample is x[n-k].
  always_comb begin
    coef = '0;
    samp = '0;
    for (int i = 0; i < HLEN; i++) begin
      if (int'(k_q) == i) samp = hist_q[i];
    end
    for (int j = 0; j < N; j++) begin
      if (int'(k_q) * L + int'(phase_q) == j) coef = WIDTH'(H_COEF[j]);
    end
  end

  // Sample history; hist_q[0] is the newest sample.
  // It shifts only when an input is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < HLEN; i++) hist_q[i] <= '0;
    end else if (accept) begin
      hist_q[0] <= x_in;
      for (int i = 1; i < HLEN; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  // Control FSM.
  // Flow: IDLE accepts a sample; MAC runs one tap per cycle;
  // OUT holds the result until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      k_q       <= '0;
      x_ready_q <= 1'b1;
      y_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= MAC;
            phase_q   <= '0;
            k_q       <= '0;
            x_ready_q <= 1'b0;
          end
        end
        MAC: begin
          if (last_term) begin
            state_q   <= OUT;
            y_valid_q <= 1'b1;
          end else begin
            k_q <= k_q + 8'd1;
          end
        end
        OUT: begin
          if (y_ready) begin
            y_valid_q <= 1'b0;
            if (int'(phase_q) < L - 1) begin
              phase_q <= phase_q + 4'd1;
              k_q     <= '0;
              state_q <= MAC;
            end else begin
              state_q   <= IDLE;
              x_ready_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          x_ready_q <= 1'b1;
          y_valid_q <= 1'b0;
        end
      endcase
    end
  end

  fir_mac #(
    .WIDTH(WIDTH),
    .ACC_W(ACC_W)
  ) u_mac (
    .clk  (clk),
    .rst  (rst),
    .clr_i(mac_clr),
    .en_i (mac_en),
    .a_i  (coef),
    .b_i  (samp),
    .acc_o(acc)
  );

endmodule

// File: tb/tb_fir_interp.sv
// Self-checking bench for fir_interp at default parameters.
// Expected outputs come from a direct evaluation of the interpolation sum
// over a sample-history queue, computed with wide plain arithmetic.
module tb_fir_interp;

  localparam int TN    = 11;
  localparam int TW    = 32;
  localparam int TL    = 2;
  localparam int THLEN = (TN + TL - 1) / TL;

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] x_in;
  logic          x_valid;
  logic          x_ready;
  logic [TW-1:0] y_out;
  logic          y_valid;
  logic          y_ready;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_acc = 0;
  int acc_gap  = 0;

  int h_ref [11] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1};
  int imp_ref [12] = '{1, 2, 3, 4, 5, 6, 5, 4, 3, 2, 1, 0};

  logic signed [TW-1:0] mh [$];
  logic [TW-1:0]        obs_log [$];
  logic [TW-1:0]        ovf_exp;

  fir_interp #(.N(TN), .WIDTH(TW), .L(TL)) dut (
    .clk    (clk),
    .rst    (rst),
    .x_in   (x_in),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .y_out  (y_out),
    .y_valid(y_valid),
    .y_ready(y_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int terms(input int p);
    return (TN - p + TL - 1) / TL;
  endfunction

  // y[n,p] = sum over k of h[k*L+p] * x[n-k]; missing history reads as zero.
  function automatic logic [TW-1:0] model_y(input int p);
    logic signed [127:0] acc;
    logic signed [127:0] xs;
    acc = '0;
    for (int k = 0; k * TL + p < TN; k++) begin
      xs = (k < mh.size()) ? 128'(mh[k]) : 128'sd0;
      acc = acc + 128'(h_ref[k*TL+p]) * xs;
    end
`ifdef FIR_INTERP_SAT_EN
    if (acc > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (acc < -128'sd2147483648) return 32'h8000_0000;
`endif
    return acc[TW-1:0];
  endfunction

  // Push one sample through all phases.
  // stall: number of cycles y_ready is held low in each OUT state.
  // hold:  keep x_valid high while the block is busy.
  task automatic send(input logic [TW-1:0] xv, input int stall, input bit hold);
    int w;
    int lat;
    logic [TW-1:0] exp_y;
    x_in    = xv;
    x_valid = 1'b1;
    y_ready = 1'b1;
    w = 0;
    while (x_ready !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 64'(w < 40), 64'(1));
    chk("no_yvalid_idle", 64'(y_valid), 64'(0));
    @(posedge clk);
    acc_gap  = cyc - last_acc;
    last_acc = cyc;
    mh.push_front(xv);
    if (mh.size() > THLEN) void'(mh.pop_back());
    @(negedge clk);
    if (!hold) x_valid = 1'b0;
    for (int p = 0; p < TL; p++) begin
      exp_y = model_y(p);
      lat = 1;
      while (y_valid !== 1'b1 && lat < 40) begin
        chk("x_ready_mac", 64'(x_ready), 64'(0));
        @(negedge clk);
        lat++;
      end
      chk("latency", 64'(lat), 64'(terms(p) + 1));
      chk("y_out", 64'(y_out), 64'(exp_y));
      chk("x_ready_out", 64'(x_ready), 64'(0));
      obs_log.push_back(y_out);
      for (int s = 0; s < stall; s++) begin
        y_ready = 1'b0;
        @(negedge clk);
        chk("stall_valid", 64'(y_valid), 64'(1));
        chk("stall_y", 64'(y_out), 64'(exp_y));
        chk("stall_xready", 64'(x_ready), 64'(0));
      end
      y_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("y_valid_drop", 64'(y_valid), 64'(0));
    end
  endtask

  initial begin
    rst     = 1'b1;
    x_in    = '0;
    x_valid = 1'b0;
    y_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_xready", 64'(x_ready), 64'(0));
    chk("rst_yvalid", 64'(y_valid), 64'(0));
    chk("rst_yout", 64'(y_out), 64'(0));
    rst = 1'b0;
    #1;
    chk("post_rst_xready", 64'(x_ready), 64'(1));
    @(negedge clk);

    // Impulse response.
    obs_log.delete();
    send(32'd1, 0, 1'b0);
    repeat (5) send(32'd0, 0, 1'b0);
    for (int i = 0; i < 12; i++) chk("impulse", 64'(obs_log[i]), 64'(imp_ref[i]));

    // DC gain: every phase sums to 18 once the history is full.
    obs_log.delete();
    repeat (8) send(32'd1, 0, 1'b0);
    for (int i = 12; i < 16; i++) chk("dc", 64'(obs_log[i]), 64'(18));

    // Back-to-back throughput with x_valid held high.
    send(32'd3, 0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      send(32'($urandom_range(0, 1000)), 0, 1'b1);
      chk("period", 64'(acc_gap), 64'(1 + TN + TL));
    end
    x_valid = 1'b0;

    // Long backpressure on every phase.
    send($urandom, 20, 1'b0);

    // Randomized samples, stalls and hold behaviour.
    for (int i = 0; i < 16; i++) begin
      send($urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
    x_valid = 1'b0;
    @(negedge clk);

    // Overflow of full-scale positive input.
`ifdef FIR_INTERP_SAT_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'hFFFF_FFEE;
`endif
    obs_log.delete();
    repeat (8) send(32'h7FFF_FFFF, 0, 1'b0);
    for (int i = 12; i < 16; i++) chk("overflow", 64'(obs_log[i]), 64'(ovf_exp));

    // Reset while the multiplier is busy: the sample must vanish.
    x_in    = 32'd5;
    x_valid = 1'b1;
    y_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    x_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midmac_rst_xready", 64'(x_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    mh.delete();
    #1;
    chk("midmac_post_xready", 64'(x_ready), 64'(1));
    chk("midmac_post_yout", 64'(y_out), 64'(0));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midmac_no_valid", 64'(y_valid), 64'(0));
    end
    obs_log.delete();
    send(32'd1, 0, 1'b0);
    repeat (5) send(32'd0, 0, 1'b0);
    for (int i = 0; i < 12; i++) chk("impulse_after_rst", 64'(obs_log[i]), 64'(imp_ref[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
